// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks program memory byte by byte, gathers an
// opcode plus two argument bytes, and holds them for the control unit until
// it retires the instruction and supplies the PC increment.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PROG_BYTES = 1024,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic [7:0]            op_code,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  input  logic [15:0]           offset,
  input  logic                  op_done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_A1    = 3'd1,
    S_A2    = 3'd2,
    S_A3    = 3'd3,
    S_VALID = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);
  // One extra bit so a program as long as the full address space still compares correctly.
  localparam logic [ADDR_WIDTH:0]   PROG_LIMIT = (ADDR_WIDTH + 1)'(PROG_BYTES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [7:0]            arg1_q, arg1_d;
  logic [7:0]            arg2_q, arg2_d;

  logic [ADDR_WIDTH-1:0] offset_ext;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic                  pc_out_of_range;

  // The control unit's offset is 16-bit signed; stretch or trim it to the PC width.
  generate
    if (ADDR_WIDTH > 16) begin : g_offset_sext
      assign offset_ext = {{(ADDR_WIDTH - 16){offset[15]}}, offset};
    end else begin : g_offset_trunc
      assign offset_ext = offset[ADDR_WIDTH-1:0];
    end
  endgenerate

  // Address arithmetic wraps naturally at the PC width.
  assign pc_plus1        = pc_q + ADDR_WIDTH'(1);
  assign pc_plus2        = pc_q + ADDR_WIDTH'(2);
  assign pc_out_of_range = ({1'b0, pc_q} >= PROG_LIMIT);

  // State, PC and fetched bytes; reset clears everything regardless of op_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_OP;
      pc_q     <= RESET_PC_V;
      opcode_q <= 8'h00;
      arg1_q   <= 8'h00;
      arg2_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      arg1_q   <= arg1_d;
      arg2_q   <= arg2_d;
    end
  end

  // Next-state logic and memory address; each read state latches the byte
  // requested in the previous cycle and requests the following one.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    arg1_d   = arg1_q;
    arg2_d   = arg2_q;
    mem_addr = pc_q;
    unique case (state_q)
      S_OP: begin
        state_d = pc_out_of_range ? S_HALT : S_A1;
      end
      S_A1: begin
        mem_addr = pc_plus1;
        opcode_d = mem_data;
        if (mem_data == 8'h00) begin
          // nop: step over the single byte and restart without presenting it
          pc_d    = pc_plus1;
          state_d = S_OP;
        end else begin
          state_d = S_A2;
        end
      end
      S_A2: begin
        mem_addr = pc_plus2;
        arg1_d   = mem_data;
        state_d  = S_A3;
      end
      S_A3: begin
        arg2_d  = mem_data;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (op_done) begin
          pc_d    = pc_q + offset_ext;
          state_d = S_OP;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_OP;
      end
    endcase
  end

  // Opcode is masked in the retire cycle so the control unit never sees it twice.
  assign op_code = (state_q == S_VALID && !op_done) ? opcode_q : 8'h00;
  assign arg1    = arg1_q;
  assign arg2    = arg2_q;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a table of chained instructions, a few
// hand-written corner sequences, and a randomized run against a
// transaction-level model of the fetch rules.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic        rst_n, op_done, halted;
  logic [15:0] offset, mem_addr, pc;
  logic [7:0]  mem_data, op_code, arg1, arg2;

  // Small DUT with a 4-byte program for the halt scenario
  logic        s_rst_n, s_op_done, s_halted;
  logic [15:0] s_offset, s_mem_addr, s_pc;
  logic [7:0]  s_mem_data, s_op_code, s_arg1, s_arg2;

  logic [7:0] rom [0:65535];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .offset(offset),
    .op_done(op_done), .pc(pc), .halted(halted)
  );

  instr_fetch #(.ADDR_WIDTH(16), .PROG_BYTES(4), .RESET_PC(0)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .op_code(s_op_code), .arg1(s_arg1), .arg2(s_arg2), .offset(s_offset),
    .op_done(s_op_done), .pc(s_pc), .halted(s_halted)
  );

  // Synchronous program memory: data one cycle after the address.
  always @(posedge clk) begin
    mem_data   <= rom[mem_addr];
    s_mem_data <= rom[s_mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance negedge by negedge until an instruction is presented or fetch halts.
  task automatic wait_event(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (op_code == 8'h00 && !halted && cyc < 200);
  endtask

  // Reset for one cycle, verify reset values, release. Ends in the S_OP cycle.
  task automatic reset_main();
    @(negedge clk);
    rst_n   = 1'b0;
    op_done = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_op_code", op_code, 8'h00);
    chk("rst_arg1", arg1, 8'h00);
    chk("rst_arg2", arg2, 8'h00);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
  endtask

  // Retire the presented instruction; ends in the cycle after op_done.
  task automatic retire(input logic [15:0] offs, input logic [15:0] exp_next);
    op_done = 1'b1;
    offset  = offs;
    #1;
    chk("done_op_code_zero", op_code, 8'h00);
    @(negedge clk);
    op_done = 1'b0;
    offset  = 16'($urandom);
    chk("next_pc", pc, exp_next);
  endtask

  typedef struct {
    logic [15:0] exp_pc;
    logic [7:0]  exp_op;
    logic [7:0]  exp_a1;
    logic [7:0]  exp_a2;
    int          exp_lat;
    logic [15:0] offs;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          cyc;
    logic [15:0] p, pc_m, offs;
    int          nops, r;

    rst_n = 1'b0; op_done = 1'b0; offset = 16'h0;
    s_rst_n = 1'b0; s_op_done = 1'b0; s_offset = 16'h0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;

    // ---------------- table-driven chain ----------------
    rom[16'h00] = 8'h10; rom[16'h01] = 8'h05; rom[16'h02] = 8'h00;
    rom[16'h03] = 8'h60; rom[16'h04] = 8'h11; rom[16'h05] = 8'h22;
    rom[16'h08] = 8'hA7; rom[16'h09] = 8'hFF; rom[16'h0A] = 8'hF8;
    rom[16'h20] = 8'h84; rom[16'h21] = 8'h01; rom[16'h22] = 8'h02;
    rom[16'h23] = 8'hB1; rom[16'h24] = 8'h33; rom[16'h25] = 8'h44;

    vecs[0] = '{16'h0000, 8'h10, 8'h05, 8'h00, 4, 16'h0002, 16'h0002}; // bipush 5
    vecs[1] = '{16'h0003, 8'h60, 8'h11, 8'h22, 6, 16'h0005, 16'h0008}; // nop at 2 skipped
    vecs[2] = '{16'h0008, 8'hA7, 8'hFF, 8'hF8, 4, 16'hFFF8, 16'h0000}; // backward branch
    vecs[3] = '{16'h0000, 8'h10, 8'h05, 8'h00, 4, 16'h0020, 16'h0020};
    vecs[4] = '{16'h0020, 8'h84, 8'h01, 8'h02, 4, 16'h0003, 16'h0023};
    vecs[5] = '{16'h0023, 8'hB1, 8'h33, 8'h44, 4, 16'h03DD, 16'h0400}; // lands on 1024

    repeat (2) @(negedge clk);
    reset_main();
    for (int i = 0; i < 6; i++) begin
      wait_event(cyc);
      chk("tbl_latency", cyc, vecs[i].exp_lat);
      chk("tbl_pc", pc, vecs[i].exp_pc);
      chk("tbl_op_code", op_code, vecs[i].exp_op);
      chk("tbl_arg1", arg1, vecs[i].exp_a1);
      chk("tbl_arg2", arg2, vecs[i].exp_a2);
      retire(vecs[i].offs, vecs[i].exp_next);
    end
    chk("halt_not_yet", halted, 1'b0);
    @(negedge clk);
    chk("halt_set", halted, 1'b1);
    for (int k = 0; k < 2; k++) begin
      op_done = 1'b1; offset = 16'hFC00;
      #1;
      chk("halt_op_code", op_code, 8'h00);
      @(negedge clk);
      op_done = 1'b0;
      chk("halt_pc_hold", pc, 16'h0400);
      chk("halt_sticky", halted, 1'b1);
    end

    // ---------------- spurious op_done in S_A2 ----------------
    reset_main();
    chk("a_mem_addr_op", mem_addr, 16'h0000);
    @(negedge clk);
    chk("a_mem_addr_a1", mem_addr, 16'h0001);
    @(negedge clk);
    chk("a_mem_addr_a2", mem_addr, 16'h0002);
    op_done = 1'b1; offset = 16'h0005;
    @(negedge clk);
    op_done = 1'b0;
    chk("a_mem_addr_a3", mem_addr, 16'h0000);
    chk("a_pc_unchanged", pc, 16'h0000);
    @(negedge clk);
    chk("a_op_code", op_code, 8'h10);
    chk("a_arg1", arg1, 8'h05);
    chk("a_pc", pc, 16'h0000);

    // ---------------- reset while VALID at 0x20 ----------------
    retire(16'h0020, 16'h0020);
    wait_event(cyc);
    chk("b_latency", cyc, 4);
    chk("b_op_code", op_code, 8'h84);
    rst_n = 1'b0; op_done = 1'b1; offset = 16'h0010;
    @(negedge clk);
    op_done = 1'b0;
    chk("b_rst_pc", pc, 16'h0000);
    chk("b_rst_op_code", op_code, 8'h00);
    chk("b_rst_arg1", arg1, 8'h00);
    chk("b_rst_arg2", arg2, 8'h00);
    rst_n = 1'b1;
    wait_event(cyc);
    chk("b_refetch_latency", cyc, 4);
    chk("b_refetch_op", op_code, 8'h10);
    chk("b_refetch_pc", pc, 16'h0000);

    // ---------------- nop at the reset PC ----------------
    rom[0] = 8'h00; rom[1] = 8'h60; rom[2] = 8'h11; rom[3] = 8'h22;
    reset_main();
    wait_event(cyc);
    chk("nop_latency", cyc, 6);
    chk("nop_op_code", op_code, 8'h60);
    chk("nop_pc", pc, 16'h0001);
    chk("nop_arg1", arg1, 8'h11);
    chk("nop_arg2", arg2, 8'h22);

    // ---------------- halt on 4-byte program ----------------
    rom[0] = 8'h10; rom[1] = 8'h05; rom[2] = 8'h00;
    rom[3] = 8'h60; rom[4] = 8'h11; rom[5] = 8'h22;
    @(negedge clk);
    s_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s_op_code0", s_op_code, 8'h10);
    s_op_done = 1'b1; s_offset = 16'h0003;
    @(negedge clk);
    s_op_done = 1'b0;
    chk("s_pc3", s_pc, 16'h0003);
    repeat (4) @(negedge clk);
    chk("s_op_code3", s_op_code, 8'h60);
    s_op_done = 1'b1; s_offset = 16'h0001;
    #1;
    chk("s_done_op_zero", s_op_code, 8'h00);
    @(negedge clk);
    s_op_done = 1'b0;
    chk("s_pc4", s_pc, 16'h0004);
    chk("s_halted_early", s_halted, 1'b0);
    @(negedge clk);
    chk("s_halted", s_halted, 1'b1);
    chk("s_halt_op_code", s_op_code, 8'h00);
    for (int k = 0; k < 2; k++) begin
      s_op_done = 1'b1; s_offset = 16'hFFFC;
      @(negedge clk);
      s_op_done = 1'b0;
      chk("s_halt_pc_hold", s_pc, 16'h0004);
      chk("s_halt_sticky", s_halted, 1'b1);
      chk("s_halt_op_zero", s_op_code, 8'h00);
    end

    // ---------------- randomized run vs. transaction model ----------------
    for (int i = 0; i < 16'h0402; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    reset_main();
    pc_m = 16'h0000;
    for (int t = 0; t < 250; t++) begin
      // Model: skip nops (2 cycles each) until a real opcode or the end of the program.
      p = pc_m;
      nops = 0;
      while (p < 16'd1024 && rom[p] == 8'h00) begin
        p++;
        nops++;
      end
      wait_event(cyc);
      if (p >= 16'd1024) begin
        chk("rnd_halted", halted, 1'b1);
        chk("rnd_halt_latency", cyc, 1 + 2 * nops);
        chk("rnd_halt_op_code", op_code, 8'h00);
        reset_main();
        pc_m = 16'h0000;
      end else begin
        chk("rnd_latency", cyc, 4 + 2 * nops);
        chk("rnd_pc", pc, p);
        chk("rnd_op_code", op_code, rom[p]);
        chk("rnd_arg1", arg1, rom[p + 16'd1]);
        chk("rnd_arg2", arg2, rom[p + 16'd2]);
        r = $urandom_range(0, 19);
        if (r < 14)      offs = 16'($urandom_range(1, 4));
        else if (r < 18) offs = 16'($urandom_range(0, 32)) - 16'd16;
        else             offs = 16'($urandom);
        pc_m = p + offs;
        retire(offs, pc_m);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the control unit. Walks program memory with a byte-addressed program counter and reads the opcode plus two argument bytes into registers. It presents them as `op_code`/`arg1`/`arg2` and holds them until the control unit signals `op_done`. It then advances the PC by the signed 16-bit `offset` the control unit produces: either the instruction length or a branch offset.

## Interface
- `ADDR_WIDTH`, 16: program counter / memory address width.
- `PROG_BYTES`, 1024: program length in bytes; a PC at or beyond this halts fetch.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_addr`  out  ADDR_WIDTH  program memory read address.
- `mem_data`  in  8  program memory read data, valid one cycle after `mem_addr`.
- `op_code`  out  8  current opcode; 0x00 whenever no instruction is valid.
- `arg1`  out  8  byte at PC+1.
- `arg2`  out  8  byte at PC+2.
- `offset`  in  16  signed PC increment from the control unit, sampled only with `op_done`.
- `op_done`  in  1  one-cycle pulse: current instruction is retired.
- `pc`  out  ADDR_WIDTH  current program counter.
- `halted`  out  1  high once PC ≥ `PROG_BYTES`; sticky until reset.

## Operation
- The control unit starts an instruction whenever `op_code` ≠ 0x00, so 0x00 is the "no instruction" marker.
- States:
  - S_OP: drive `mem_addr`=PC.
  - S_A1: latch opcode from `mem_data`, drive PC+1.
  - S_A2: latch arg1, drive PC+2.
  - S_A3: latch arg2.
  - VALID: present the instruction.
  - HALT.
- Transitions:
  - S_OP→HALT if PC ≥ `PROG_BYTES`, else S_OP→S_A1.
  - S_A1→S_A2→S_A3→VALID.
  - VALID stays until `op_done`, then PC ← PC + sign_extend(`offset`) and goes to S_OP.
  - HALT is absorbing.
- Opcode 0x00 (nop) latched in S_A1: PC ← PC+1, return to S_OP. The nop never appears on `op_code`.
- All three bytes are always fetched regardless of argument count. Bytes read past `PROG_BYTES` are latched but carry no meaning.
- Address arithmetic is modulo 2^ADDR_WIDTH.
  - PC+1 and PC+2 wrap.
  - A negative offset below 0 wraps.
  - A wrapped PC ≥ `PROG_BYTES` halts.
- `op_code` = opcode register when state is VALID and `op_done` is low, else 0x00. It is gated combinationally so the control unit's idle state never re-samples a retired opcode in the `op_done` cycle.
- `arg1`/`arg2` hold their last latched values outside VALID.
- `op_done` outside VALID is ignored; PC is unchanged.
- `offset` is ignored unless `op_done` is high in VALID.

## Timing
- Reset values:
  - `op_code`=0x00, `arg1`=0x00, `arg2`=0x00.
  - `pc`=`mem_addr`=`RESET_PC`.
  - `halted`=0.
  - state=S_OP.
- Reset asserted in any state, including VALID and mid-read, takes effect at the next edge. Latched bytes clear and the PC reloads; no `op_done` is honoured in that cycle.
- Fetch latency: 4 cycles from entering S_OP to `op_code` valid (S_OP, S_A1, S_A2, S_A3, then VALID).
- Each skipped nop adds 2 cycles.
- `op_done` in cycle N gives:
  - `op_code`=0x00 in cycle N;
  - new PC visible in N+1;
  - next instruction valid in N+5 at the earliest.
- `mem_addr` is a combinational function of state and PC:
  - S_OP: PC; S_A1: PC+1; S_A2: PC+2;
  - otherwise PC.
- `halted` rises the cycle after S_OP detects the out-of-range PC. `op_code` stays 0x00 from then on.

## Test plan
- Reset, ROM[0..2]=0x10,0x05,0x00 (bipush 5) -> `op_code`=0x10 and `arg1`=0x05 on the 4th cycle after reset release. Pulse `op_done` with `offset`=2 -> `op_code`=0x00 that cycle, `pc`=2 next cycle.
- Backward branch: instruction at PC=8 (ROM[8..10]=0xA7,0xFF,0xF8), `op_done` with `offset`=0xFFF8 -> `pc`=0, then opcode at ROM[0] presented.
- Nop skip: ROM[0]=0x00, ROM[1..3]=0x60,0x11,0x22 -> `op_code` stays 0x00 until 0x60 appears at cycle 6, with `pc`=1, `arg1`=0x11, `arg2`=0x22.
- Spurious `op_done` during S_A2 with `offset`=5 -> PC, state and latched bytes unaffected.
- Halt: `PROG_BYTES`=4, instruction at PC=3 retired with `offset`=1 -> `halted`=1 two cycles later; `op_code` remains 0x00 and further `op_done` pulses are ignored.
- Reset mid-operation: `rst_n` low for one cycle while in VALID at PC=0x20 -> next cycle `pc`=`RESET_PC`, `op_code`=0x00, `arg1`=`arg2`=0x00; refetch from `RESET_PC` completes 4 cycles after release.
